data_mem_unit: RTL and testbench



---
 rtl/data_mem_unit_pkg.sv | 52 +++++
 rtl/data_mem_unit_if.sv | 27 ++
 rtl/data_mem_unit_load_align.sv | 32 +++
 rtl/data_mem_unit.sv | 196 +++++++++++++++++++
 tb/tb_data_mem_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_unit_pkg.sv
// Shared types and helpers for the data memory unit.
//   mem_unit_state_t : FSM encoding (IDLE, BUSY, DONE)
//   load_funct3_t    : RV32I load width/sign codes
//   store_funct3_t   : RV32I store width codes
//   helpers          : funct3 legality and address alignment checks
package data_mem_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_unit_state_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  function automatic logic is_legal_load(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal_store(input logic [2:0] f3);
    case (f3)
      F3_SB, F3_SH, F3_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // funct3[1:0] carries the access size for both loads and stores
  // (00 byte, 01 half, 10 word); bit 2 only selects zero-extension.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return (off[0] == 1'b0);
      2'b10:   return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_unit_if.sv
// Data-cache port bundle between the memory stage and the data cache.
//   master : memory unit side (drives strobes, address, data, byte mask)
//   slave  : cache side (drives the done pulse and read word)
// Handshake: dmem_read/dmem_write act as "valid" and stay high, with
// address/wdata/byte_enable stable, until the cache returns a single-cycle
// dmem_resp ("ready"); the transfer completes on the edge where both are
// high. dmem_rdata is only meaningful in the dmem_resp cycle. At most one
// access is outstanding.
interface data_mem_unit_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/data_mem_unit_load_align.sv
// Combinational load alignment: picks the addressed byte/half/word out of
// the cache word and sign- or zero-extends it.
//   rdata_i  : 32-bit word from the cache
//   offset_i : byte offset within the word (addr[1:0])
//   funct3_i : load width/signedness code
//   data_o   : aligned, extended load result
module data_mem_unit_load_align
  import data_mem_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Bring the addressed byte lane down to bit 0.
  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data_o = {24'd0, shifted[7:0]};
      F3_LHU:  data_o = {16'd0, shifted[15:0]};
      default: data_o = shifted;  // lw: offset is always 0 here
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Memory-stage data memory unit. Takes the mem fields of the control word
// plus the ALU address, runs a single-outstanding access on the data cache
// port, produces byte enables and replicated store data, and returns the
// aligned/extended load result.
//   clk, rst_n     : clock, synchronous active-low reset
//   mem_read/write : load / store request from the control word
//   funct3         : access width and signedness
//   addr           : byte address
//   store_data     : rs2 value for stores
//   stall          : combinational pipeline hold
//   load_data      : registered load result, valid with load_valid
//   load_valid     : one-cycle pulse in the DONE cycle of a load
//   access_fault   : one-cycle pulse on illegal request or watchdog timeout
//   dmem           : cache port (master side)
//   dbg_state_o    : current FSM state
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  load_valid,
  output logic                  access_fault,
  data_mem_unit_if.master       dmem,
  output mem_unit_state_t       dbg_state_o
);

  mem_unit_state_t state_q, state_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] wdog_q, wdog_d;

  logic        req, is_ld, is_st, legal;
  logic [3:0]  be_enc;
  logic [31:0] wdata_enc;
  logic [31:0] aligned;
  logic [31:0] wdog_inc;

  assign req   = mem_read | mem_write;
  assign is_ld = mem_read & ~mem_write;
  assign is_st = mem_write & ~mem_read;
  assign legal = ((is_ld & is_legal_load(funct3)) | (is_st & is_legal_store(funct3)))
                 & is_aligned(funct3, addr[1:0]);

  assign wdog_inc = wdog_q + 32'd1;

  // Store lane encoding; loads never write any byte.
  always_comb begin
    be_enc    = 4'b0000;
    wdata_enc = store_data;
    if (is_st) begin
      case (funct3)
        F3_SB: begin
          be_enc    = 4'b0001 << addr[1:0];
          wdata_enc = {4{store_data[7:0]}};
        end
        F3_SH: begin
          be_enc    = 4'b0011 << addr[1:0];
          wdata_enc = {2{store_data[15:0]}};
        end
        default: begin
          be_enc    = 4'b1111;
          wdata_enc = store_data;
        end
      endcase
    end
  end

  data_mem_unit_load_align u_load_align (
    .rdata_i  (dmem.dmem_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (aligned)
  );

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    f3_d         = f3_q;
    off_d        = off_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
    wdog_d       = wdog_q;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (legal) begin
            rd_d    = is_ld;
            wr_d    = is_st;
            addr_d  = {addr[31:2], 2'b00};
            wdata_d = wdata_enc;
            be_d    = be_enc;
            f3_d    = funct3;
            off_d   = addr[1:0];
            wdog_d  = 32'd0;
            stall   = 1'b1;
            state_d = BUSY;
          end else begin
            // Rejected without touching the cache; pipeline keeps moving.
            fault_d = 1'b1;
          end
        end
      end

      BUSY: begin
        stall  = 1'b1;
        wdog_d = wdog_inc;
        if (dmem.dmem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
          if (rd_q) begin
            load_data_d  = aligned;
            load_valid_d = 1'b1;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (wdog_inc == TIMEOUT_CYCLES)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          fault_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        // Inputs still describe the instruction that just finished.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      wdog_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
      wdog_q       <= wdog_d;
    end
  end

  assign dmem.dmem_read        = rd_q;
  assign dmem.dmem_write       = wr_q;
  assign dmem.dmem_address     = addr_q;
  assign dmem.dmem_wdata       = wdata_q;
  assign dmem.dmem_byte_enable = be_q;
  assign load_data             = load_data_q;
  assign load_valid            = load_valid_q;
  assign access_fault          = fault_q;
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: cache responses are driven by hand,
// expected load results go through a scoreboard queue.
module tb_data_mem_unit;
  import data_mem_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_read, mem_write;
  logic [2:0]      funct3;
  logic [31:0]     addr, store_data;
  logic            stall, load_valid, access_fault;
  logic [31:0]     load_data;
  mem_unit_state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  ld_codes[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  data_mem_unit_if dmem_bus ();

  data_mem_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .access_fault (access_fault),
    .dmem         (dmem_bus),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // ---------------- check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
  endtask

  task automatic clear_req();
    drive_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  // One legal access; the cache answers resp_after cycles after the strobe.
  task automatic run_legal(input string tag, input logic rd, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input int resp_after,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
    logic [31:0] exp_ld;
    @(negedge clk);
    drive_req(rd, ~rd, f3, a, sd);
    if (rd) exp_q.push_back(ref_load(f3, a[1:0], rdata));
    #1 check({tag, ":stall_req"}, stall, 1);
    @(negedge clk);
    check({tag, ":strobes"}, {dmem_bus.dmem_read, dmem_bus.dmem_write}, {rd, ~rd});
    check({tag, ":address"}, dmem_bus.dmem_address, {a[31:2], 2'b00});
    check({tag, ":byte_en"}, dmem_bus.dmem_byte_enable, exp_be);
    if (!rd) check({tag, ":wdata"}, dmem_bus.dmem_wdata, exp_wdata);
    for (int k = 0; k < resp_after; k++) begin
      check({tag, ":stall_busy"}, stall, 1);
      @(negedge clk);
      check({tag, ":strobe_held"}, {dmem_bus.dmem_read, dmem_bus.dmem_write}, {rd, ~rd});
    end
    dmem_bus.dmem_resp  = 1'b1;
    dmem_bus.dmem_rdata = rdata;
    #1 check({tag, ":stall_resp"}, stall, 1);
    @(negedge clk);
    dmem_bus.dmem_resp  = 1'b0;
    dmem_bus.dmem_rdata = $urandom;
    check({tag, ":done_state"}, {30'd0, dbg_state}, {30'd0, DONE});
    check({tag, ":done_stall"}, stall, 0);
    check({tag, ":done_strobes"}, {dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);
    check({tag, ":load_valid"}, load_valid, rd);
    check({tag, ":fault"}, access_fault, 0);
    if (load_valid === 1'b1) begin
      if (exp_q.size() == 0) check({tag, ":unexpected_load"}, load_valid, 0);
      else begin
        exp_ld = exp_q.pop_front();
        check({tag, ":load_data"}, load_data, exp_ld);
      end
    end
    clear_req();
    @(negedge clk);
    check({tag, ":idle"}, {30'd0, dbg_state}, {30'd0, IDLE});
    check({tag, ":valid_clear"}, load_valid, 0);
  endtask

  // Illegal request: one-cycle fault, no cache access, no stall.
  task automatic run_illegal(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    drive_req(rd, wr, f3, a, 32'h5555_AAAA);
    #1 check({tag, ":stall"}, stall, 0);
    @(negedge clk);
    clear_req();
    check({tag, ":fault"}, access_fault, 1);
    check({tag, ":no_strobe"}, {dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);
    check({tag, ":state"}, {30'd0, dbg_state}, {30'd0, IDLE});
    @(negedge clk);
    check({tag, ":fault_clear"}, access_fault, 0);
    check({tag, ":no_strobe2"}, {dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] a, w;

    clear_req();
    dmem_bus.dmem_resp  = 1'b0;
    dmem_bus.dmem_rdata = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst:state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("rst:strobes", {dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);
    check("rst:address", dmem_bus.dmem_address, 0);
    check("rst:wdata", dmem_bus.dmem_wdata, 0);
    check("rst:byte_en", dmem_bus.dmem_byte_enable, 0);
    check("rst:load", {load_data[31:0]}, 0);
    check("rst:valid_fault", {load_valid, access_fault}, 0);
    check("rst:stall", stall, 0);
    rst_n = 1'b1;

    // Loads from the directed table
    run_legal("lw_100",  1'b1, 3'b010, 32'h100, 32'd0, 0, 32'hDEADBEEF, 4'b0000, 32'd0);
    run_legal("lb_203",  1'b1, 3'b000, 32'h203, 32'd0, 2, 32'h80FF7F01, 4'b0000, 32'd0);
    run_legal("lbu_203", 1'b1, 3'b100, 32'h203, 32'd0, 1, 32'h80FF7F01, 4'b0000, 32'd0);
    run_legal("lhu_202", 1'b1, 3'b101, 32'h202, 32'd0, 0, 32'h80FF7F01, 4'b0000, 32'd0);
    run_legal("lh_202",  1'b1, 3'b001, 32'h202, 32'd0, 0, 32'h80FF7F01, 4'b0000, 32'd0);
    run_legal("lb_201",  1'b1, 3'b000, 32'h201, 32'd0, 0, 32'h80FF7F01, 4'b0000, 32'd0);
    run_legal("lh_200",  1'b1, 3'b001, 32'h200, 32'd0, 1, 32'h80FF7F01, 4'b0000, 32'd0);

    // Stores
    run_legal("sh_302", 1'b0, 3'b001, 32'h302, 32'h1234ABCD, 0, 32'd0, 4'b1100, 32'hABCDABCD);
    run_legal("sb_301", 1'b0, 3'b000, 32'h301, 32'h000000A5, 1, 32'd0, 4'b0010, 32'hA5A5A5A5);
    run_legal("sb_303", 1'b0, 3'b000, 32'h303, 32'hFFFFFF3C, 0, 32'd0, 4'b1000, 32'h3C3C3C3C);
    run_legal("sh_300", 1'b0, 3'b001, 32'h300, 32'h77778421, 0, 32'd0, 4'b0011, 32'h84218421);
    run_legal("sw_304", 1'b0, 3'b010, 32'h304, 32'hCAFEF00D, 2, 32'd0, 4'b1111, 32'hCAFEF00D);

    // Illegal requests
    run_illegal("lw_mis",   1'b1, 1'b0, 3'b010, 32'h101);
    run_illegal("rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h100);
    run_illegal("lh_mis",   1'b1, 1'b0, 3'b001, 32'h201);
    run_illegal("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h100);
    run_illegal("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h100);
    run_illegal("sw_mis",   1'b0, 1'b1, 3'b010, 32'h102);

    // Watchdog: no response for TIMEOUT_CYCLES busy cycles
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'h400, 32'd0);
    #1 check("wd:stall_req", stall, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("wd:strobe", dmem_bus.dmem_read, 1);
      check("wd:stall", stall, 1);
      check("wd:no_fault", access_fault, 0);
    end
    @(negedge clk);
    check("wd:strobe_drop", dmem_bus.dmem_read, 0);
    check("wd:fault", access_fault, 1);
    check("wd:no_valid", load_valid, 0);
    check("wd:done_stall", stall, 0);
    check("wd:done", {30'd0, dbg_state}, {30'd0, DONE});
    clear_req();
    @(negedge clk);
    check("wd:idle", {30'd0, dbg_state}, {30'd0, IDLE});
    check("wd:fault_clear", access_fault, 0);

    // Reset in the third busy cycle, then a stale response
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'h500, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rb:strobe", dmem_bus.dmem_read, 1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rb:strobe_low", {dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);
    check("rb:state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst_n = 1'b1;
    clear_req();
    dmem_bus.dmem_resp  = 1'b1;
    dmem_bus.dmem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    dmem_bus.dmem_resp = 1'b0;
    check("rb:late_resp_valid", load_valid, 0);
    check("rb:late_resp_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("rb:late_resp_strobe", {dmem_bus.dmem_read, dmem_bus.dmem_write}, 0);
    run_legal("rb:lw_after", 1'b1, 3'b010, 32'h504, 32'd0, 1, 32'h13579BDF, 4'b0000, 32'd0);

    // Random legal loads
    for (int i = 0; i < 8; i++) begin
      f3 = ld_codes[$urandom_range(0, 4)];
      case (f3[1:0])
        2'b10:   off = 2'd0;
        2'b01:   off = 2'($urandom_range(0, 1) * 2);
        default: off = 2'($urandom_range(0, 3));
      endcase
      a = ($urandom & 32'hFFFF_FFFC) | {30'd0, off};
      w = $urandom;
      run_legal("rand_ld", 1'b1, f3, a, 32'd0, $urandom_range(0, 3), w, 4'b0000, 32'd0);
    end

    check("sb:drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
